// File: rtl/tlcd_reader.sv
// rtl/tlcd_reader.sv - HD44780 Text LCD read engine: single reads and busy-flag polling
// Drives E/RS/RW while it owns the bus; a top-level mux hands the pins over on bus_own.
module tlcd_reader #(
  parameter int SETUP_CYC   = 4,
  parameter int E_HIGH_CYC  = 25,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 25,
  parameter int POLL_MAX    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       poll_req,
  input  logic [7:0] TLCD_D_in,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic       bus_own,
  output logic       rd_busy,
  output logic       rd_done,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       poll_timeout
);

  localparam int M1      = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int M2      = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int MAX_CYC = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PCNT_W  = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_RECOVER} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PCNT_W-1:0] r_pcnt;
  logic              r_rs;
  logic              r_poll;
  logic              r_done;
  logic              r_timeout;
  logic [7:0]        r_data;
  logic              r_bf;
  logic [6:0]        r_ac;

  logic w_accept;
  logic w_phase_end;
  logic w_sample;
  logic w_done;
  logic w_poll_again;
  logic w_timeout_set;
  logic w_bus_own;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_phase_end   = 1'b0;
    w_sample      = 1'b0;
    w_done        = 1'b0;
    w_poll_again  = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req || poll_req) begin
          w_accept     = 1'b1;
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
          w_phase_end  = 1'b1;
          w_next_state = S_EHIGH;
        end
      end
      S_EHIGH: begin
        if (r_cnt == CNT_W'(E_HIGH_CYC - 1)) begin
          w_phase_end  = 1'b1;
          w_sample     = 1'b1;
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
          w_phase_end  = 1'b1;
          w_next_state = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == CNT_W'(RECOVER_CYC - 1)) begin
          w_phase_end = 1'b1;
          // Poll re-enters SETUP directly so rd_busy never drops between BF reads
          if (r_poll && r_data[7] && (r_pcnt != PCNT_W'(POLL_MAX))) begin
            w_poll_again = 1'b1;
            w_next_state = S_SETUP;
          end else begin
            w_done        = 1'b1;
            w_timeout_set = r_poll && r_data[7];
            w_next_state  = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pcnt    <= '0;
      r_rs      <= 1'b0;
      r_poll    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_data    <= 8'h00;
      r_bf      <= 1'b1;
      r_ac      <= 7'h00;
    end else begin
      r_done <= w_done;
      if (w_accept || w_phase_end) r_cnt <= '0;
      else if (r_state != S_IDLE)  r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_rs   <= rd_req ? rd_rs : 1'b0;
        r_poll <= !rd_req;
        if (!rd_req) begin
          r_pcnt    <= PCNT_W'(1);
          r_timeout <= 1'b0;
        end
      end
      if (w_sample) begin
        r_data <= TLCD_D_in;
        if (!r_rs) begin
          r_bf <= TLCD_D_in[7];
          r_ac <= TLCD_D_in[6:0];
        end
      end
      if (w_poll_again) r_pcnt <= r_pcnt + 1'b1;
      if (w_done) begin
        r_poll <= 1'b0;
        if (r_poll) r_timeout <= w_timeout_set;
      end
    end
  end

  assign w_bus_own    = (r_state == S_SETUP) || (r_state == S_EHIGH) || (r_state == S_HOLD);
  assign bus_own      = w_bus_own;
  assign TLCD_E       = (r_state == S_EHIGH);
  assign TLCD_RW      = w_bus_own;
  assign TLCD_RS      = r_rs && w_bus_own;
  assign rd_busy      = (r_state != S_IDLE);
  assign rd_done      = r_done;
  assign rd_data      = r_data;
  assign busy_flag    = r_bf;
  assign addr_cnt     = r_ac;
  assign poll_timeout = r_timeout;

endmodule

// File: doc/tlcd_reader.md
Name: tlcd_reader

Overview:
- Read-side engine for the HD44780-compatible Text LCD bus, the counterpart of the existing write-only TextLCD controller.
- Performs single read cycles with RW=1: either busy flag plus address counter (RS=0), or DDRAM/CGRAM data (RS=1).
- Also provides a busy-poll mode, so the write controller can wait on BF instead of fixed delays.
- Sits beside the LCD write core. A top-level mux gives it the TLCD control lines and tristates D0-D7 while bus_own=1.

Parameters:
SETUP_CYC, 4, clk cycles with RS/RW valid and E low before E rises (tAS, 80 ns at 50 MHz)
E_HIGH_CYC, 25, clk cycles E held high (PW_EH, 500 ns)
HOLD_CYC, 2, clk cycles RS/RW held after E falls (tAH)
RECOVER_CYC, 25, idle clk cycles after hold before next access (completes tcycE ≥ 1000 ns)
POLL_MAX, 1000, maximum BF reads per poll before timeout

Ports:
clk  in  1  50 MHz system clock
rst  in  1  synchronous, active-high reset
rd_req  in  1  single-cycle request for one read access
rd_rs  in  1  register select for rd_req (0 = BF/address, 1 = data)
poll_req  in  1  single-cycle request to poll BF until clear
TLCD_D_in  in  8  LCD data pins as sampled from the pad
TLCD_E  out  1  LCD enable
TLCD_RS  out  1  LCD register select
TLCD_RW  out  1  LCD read/write (1 = read)
bus_own  out  1  1 = reader owns the TLCD bus; writer output drivers must be disabled
rd_busy  out  1  access or poll in progress
rd_done  out  1  single-cycle pulse at completion
rd_data  out  8  last sampled D7..D0
busy_flag  out  1  D7 of the last RS=0 read
addr_cnt  out  7  D6..D0 of the last RS=0 read
poll_timeout  out  1  last poll ended without BF clearing

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: TLCD_E=0, TLCD_RS=0, TLCD_RW=0, bus_own=0, rd_busy=0, rd_done=0, rd_data=0, busy_flag=1, addr_cnt=0, poll_timeout=0. The FSM goes to IDLE.
- rst asserted mid-access forces these values at the next edge. E drops immediately and no rd_done is issued.
- States: IDLE, SETUP, EHIGH, HOLD, RECOVER. A poll flag and a 10-bit poll counter run alongside the FSM.
- Requests are accepted only in IDLE.
  - rd_req or poll_req seen at edge k starts the access. rd_busy=1 and bus_own=1 from cycle k+1.
  - Requests arriving while rd_busy=1 are dropped with no queueing.
  - If rd_req and poll_req are high in the same cycle, rd_req wins and poll_req is ignored.
- A poll latches RS=0. rd_req latches rd_rs at acceptance, and that value holds for the whole access.
- Access sequence:
  - SETUP: RW=1, RS=latched value, E=0, for SETUP_CYC cycles.
  - EHIGH: E=1 for E_HIGH_CYC cycles. TLCD_D_in is registered into rd_data on the last EHIGH cycle.
  - If RS=0, busy_flag and addr_cnt are updated from that same sample. If RS=1, they keep their previous values.
  - HOLD: E=0, with RS and RW unchanged, for HOLD_CYC cycles.
  - RECOVER: RW=0, RS=0, bus_own=0, E=0, for RECOVER_CYC cycles.
- Single read:
  - After RECOVER, the FSM returns to IDLE and rd_done=1 for one cycle. rd_busy=0 in that same cycle.
  - Latency from accept edge to the rd_done cycle = 1+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+RECOVER_CYC = 57 cycles with default parameters.
- Poll:
  - Accepting a poll clears poll_timeout and sets the poll counter to 1.
  - At the end of each RECOVER, if the sampled D7=0, the poll finishes: rd_done pulses and poll_timeout=0.
  - If D7=1 and counter=POLL_MAX, the poll finishes: rd_done pulses and poll_timeout=1.
  - Otherwise the counter increments and the FSM goes directly back to SETUP, without an IDLE cycle. rd_busy stays 1 between reads.
- poll_timeout is sticky until the next accepted poll_req or rst. A single rd_req does not change it.
- TLCD_E is never high while bus_own=0.
- TLCD_RW=1 only in SETUP, EHIGH and HOLD.
- Counter widths must hold the parameter values without wrap.

Test Plan:
1. rst for 3 cycles, then idle → all outputs at reset values, busy_flag=1, E never toggles.
2. rd_req=1, rd_rs=0, TLCD_D_in=8'h45 held → RW=1 for 31 cycles, E high for exactly 25 cycles, rd_data=8'h45, busy_flag=0, addr_cnt=7'h45; rd_done 57 cycles after accept.
3. rd_req=1, rd_rs=1, TLCD_D_in=8'h41 → RS=1 through HOLD, rd_data=8'h41, busy_flag and addr_cnt unchanged.
4. poll_req with D7 model returning 1 for the first 3 reads, then 8'h00 → exactly 4 E pulses, a single rd_done, poll_timeout=0, busy_flag=0.
5. poll_req with POLL_MAX=5 and TLCD_D_in=8'h80 constant → 5 E pulses, rd_done, poll_timeout=1; a following rd_req leaves poll_timeout=1.
6. rd_req and poll_req in the same cycle, a second rd_req during EHIGH, and rst asserted during EHIGH → single read performed, extra request dropped, E=0 and bus_own=0 at the edge after rst, no rd_done.
